// File: rtl/sync_filter.sv
// sync_filter: per-channel STAGES-deep synchronizer, optional debounce filter
// (enabled by defining SYNC_FILTER_DEBOUNCE_EN), registered dout/rise/fall.
(* keep_hierarchy = "yes" *)
module sync_filter #(
   parameter int unsigned      WIDTH     = 1,
   parameter int unsigned      STAGES    = 2,
   parameter int unsigned      FILTER    = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall
);

   if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("sync_filter: WIDTH must be within 1..32");
   end
   if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
      $error("sync_filter: STAGES must be within 2..4");
   end
   if (FILTER < 1 || FILTER > 255) begin : g_bad_filter
      $error("sync_filter: FILTER must be within 1..255");
   end

   (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync_q [STAGES];
   logic [WIDTH-1:0] s;
   logic [WIDTH-1:0] dout_next;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned k = 0; k < STAGES; k++) sync_q[k] <= RESET_VAL;
      end else begin
         sync_q[0] <= din;
         for (int unsigned k = 1; k < STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
   end

   assign s = sync_q[STAGES-1];

`ifdef SYNC_FILTER_DEBOUNCE_EN
   localparam int unsigned   CW       = $clog2(FILTER + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(FILTER - 1);

   logic [CW-1:0] cnt [WIDTH];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < WIDTH; i++) cnt[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < WIDTH; i++) begin
            // Agreement or acceptance of the new level both drop all credit.
            if (s[i] == dout[i] || cnt[i] == CNT_LAST) cnt[i] <= '0;
            else                                       cnt[i] <= cnt[i] + CW'(1);
         end
      end
   end

   always_comb begin
      dout_next = dout;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (s[i] != dout[i] && cnt[i] == CNT_LAST) dout_next[i] = s[i];
      end
   end
`else
   always_comb begin
      dout_next = s;
   end
`endif

   // Pulses come from the same next-state as dout so they align with its change.
   always_ff @(posedge clk) begin
      if (reset) begin
         dout <= RESET_VAL;
         rise <= '0;
         fall <= '0;
      end else begin
         dout <= dout_next;
         rise <= dout_next & ~dout;
         fall <= ~dout_next & dout;
      end
   end

endmodule

// File: tb/tb_sync_filter.sv
// Self-checking bench for sync_filter (WIDTH=4, STAGES=2, FILTER=4, RESET_VAL=0);
// follows SYNC_FILTER_DEBOUNCE_EN the same way the design does.
module tb_sync_filter;

   localparam int unsigned WIDTH     = 4;
   localparam int unsigned STAGES    = 2;
   localparam int unsigned FILTER    = 4;
   localparam logic [3:0]  RESET_VAL = 4'h0;
`ifdef SYNC_FILTER_DEBOUNCE_EN
   localparam bit DEB = 1'b1;
`else
   localparam bit DEB = 1'b0;
`endif
   localparam int LAT = DEB ? int'(STAGES + FILTER) : int'(STAGES + 1);

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] din = 4'h0;
   logic [3:0] dout, rise, fall;

   sync_filter #(
      .WIDTH(WIDTH),
      .STAGES(STAGES),
      .FILTER(FILTER),
      .RESET_VAL(RESET_VAL)
   ) dut (
      .clk(clk),
      .reset(reset),
      .din(din),
      .dout(dout),
      .rise(rise),
      .fall(fall)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference: din sample history, and window of synchronized values seen since reset.
   logic [3:0] samp [$];
   logic [3:0] s_hist [$];
   logic [3:0] m_dout, m_rise, m_fall;

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input logic rst, input logic [3:0] d);
      logic [3:0] s_pre, nd;
      bit all_diff;
      if (rst) begin
         samp.delete();
         repeat (STAGES) samp.push_back(RESET_VAL);
         s_hist.delete();
         m_dout = RESET_VAL;
         m_rise = 4'h0;
         m_fall = 4'h0;
         return;
      end
      s_pre = samp[samp.size() - STAGES];
      samp.push_back(d);
      if (samp.size() > 16) void'(samp.pop_front());
      s_hist.push_back(s_pre);
      if (s_hist.size() > FILTER) void'(s_hist.pop_front());
      nd = m_dout;
      if (DEB) begin
         // A level is accepted once the last FILTER synchronized samples all disagree.
         for (int i = 0; i < 4; i++) begin
            all_diff = (s_hist.size() == FILTER);
            foreach (s_hist[k]) if (s_hist[k][i] == m_dout[i]) all_diff = 1'b0;
            if (all_diff) nd[i] = ~m_dout[i];
         end
      end else begin
         nd = s_pre;
      end
      m_rise = nd & ~m_dout;
      m_fall = ~nd & m_dout;
      m_dout = nd;
   endtask

   task automatic cycle(input logic rst, input logic [3:0] d, input string tag);
      @(negedge clk);
      reset = rst;
      din   = d;
      @(posedge clk);
      model_edge(rst, d);
      #1;
      check({tag, "_dout"}, dout, m_dout);
      check({tag, "_rise"}, rise, m_rise);
      check({tag, "_fall"}, fall, m_fall);
   endtask

   initial begin
      int pulses;
      logic [3:0] cur;

      // din high through reset; release must not pulse, then accept after LAT edges.
      repeat (3) cycle(1'b1, 4'hF, "rst");
      check("rst_dout_zero", dout, 4'h0);
      for (int e = 1; e <= LAT + 2; e++) begin
         cycle(1'b0, 4'hF, "rel");
         check("rel_dout", dout, (e >= LAT) ? 4'hF : 4'h0);
         check("rel_rise", rise, (e == LAT) ? 4'hF : 4'h0);
      end

      // All channels fall together.
      for (int e = 1; e <= LAT + 2; e++) begin
         cycle(1'b0, 4'h0, "fall");
         check("fall_dout", dout, (e >= LAT) ? 4'h0 : 4'hF);
         check("fall_fall", fall, (e == LAT) ? 4'hF : 4'h0);
         check("fall_rise", rise, 4'h0);
      end

      // Short pulse on din[0]: filtered out entirely when debouncing.
      for (int e = 1; e <= 11; e++) begin
         cycle(1'b0, (e <= 3) ? 4'h1 : 4'h0, "short");
`ifdef SYNC_FILTER_DEBOUNCE_EN
         check("short_quiet", dout | rise | fall, 4'h0);
`endif
      end

      // din[1]: high 3, low 1, then high; counting restarts from the final rise.
      pulses = 0;
      for (int e = 1; e <= 4; e++) begin
         cycle(1'b0, (e <= 3) ? 4'h2 : 4'h0, "restart_a");
         pulses += $countones(rise & 4'h2);
      end
      for (int j = 1; j <= 10; j++) begin
         cycle(1'b0, 4'h2, "restart_b");
         pulses += $countones(rise & 4'h2);
`ifdef SYNC_FILTER_DEBOUNCE_EN
         check("restart_dout", dout & 4'h2, (j >= LAT) ? 4'h2 : 4'h0);
`endif
      end
      check("restart_pulses", 4'(pulses), DEB ? 4'd1 : 4'd2);

      repeat (10) cycle(1'b0, 4'h0, "settle");

      // Reset in the middle of filtering din[2], then a full latency again.
      repeat (4) cycle(1'b0, 4'h4, "midf");
      cycle(1'b1, 4'h4, "midf_rst");
      check("midf_rst_dout", dout, 4'h0);
      check("midf_rst_pulse", rise | fall, 4'h0);
      for (int e = 1; e <= LAT + 2; e++) begin
         cycle(1'b0, 4'h4, "midf_rel");
         check("midf_rel_dout", dout, (e >= LAT) ? 4'h4 : 4'h0);
         check("midf_rel_rise", rise, (e == LAT) ? 4'h4 : 4'h0);
      end

      repeat (10) cycle(1'b0, 4'h0, "settle2");

      // One-cycle glitch on din[3]: passes through unfiltered, suppressed when debouncing.
      for (int e = 1; e <= 6; e++) begin
         cycle(1'b0, (e == 1) ? 4'h8 : 4'h0, "glitch");
         check("glitch_dout", dout, (!DEB && e == 3) ? 4'h8 : 4'h0);
         check("glitch_rise", rise, (!DEB && e == 3) ? 4'h8 : 4'h0);
         check("glitch_fall", fall, (!DEB && e == 4) ? 4'h8 : 4'h0);
      end

      // Random slowly-toggling levels with occasional resets.
      cur = 4'h0;
      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(3) == 0) cur ^= 4'($urandom_range(15));
         cycle(($urandom_range(63) == 0), cur, "rand");
         check("rand_excl", rise & fall, 4'h0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
